// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running 640x480@60 pixel-timing generator (coordinates, draw enable, syncs).
// Latency: DrawX/DrawY/blank/line_start/frame_start describe the current pixel; hs/vs lag it by PIPE_DELAY cycles.
// Backpressure: none. The block runs every vga_clk cycle and the consumer samples on every edge.
//
// Ports:
//   vga_clk      pixel clock, rising-edge
//   reset        synchronous active-high reset
//   DrawX/DrawY  horizontal/vertical pixel counters
//   blank        high inside the visible window ("draw")
//   hs/vs        active-low syncs, delayed PIPE_DELAY cycles to match registered RGB
//   line_start   one-cycle pulse at DrawX == 0
//   frame_start  one-cycle pulse at DrawX == 0 and DrawY == 0
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 1
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_bad_delay
      $error("vga_timing_gen: PIPE_DELAY must be in 0..4");
    end
  endgenerate

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  // Thresholds are one bit wider so an end-of-range equal to 1024 does not wrap to 0.
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] hc, vc;
  logic [9:0] hc_nxt, vc_nxt;
  logic       hs_raw, vs_raw;

  always_comb begin
    hc_nxt = (hc == H_LAST) ? 10'd0 : hc + 10'd1;
    vc_nxt = vc;
    if (hc == H_LAST) begin
      vc_nxt = (vc == V_LAST) ? 10'd0 : vc + 10'd1;
    end
  end

  // Flags are derived from the next counter values so they are aligned with DrawX/DrawY.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hc          <= H_LAST;
      vc          <= V_LAST;
      blank       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      hs_raw      <= 1'b1;
      vs_raw      <= 1'b1;
    end else begin
      hc          <= hc_nxt;
      vc          <= vc_nxt;
      blank       <= ({1'b0, hc_nxt} < H_ACT) && ({1'b0, vc_nxt} < V_ACT);
      line_start  <= (hc_nxt == 10'd0);
      frame_start <= (hc_nxt == 10'd0) && (vc_nxt == 10'd0);
      hs_raw      <= !(({1'b0, hc_nxt} >= HS_BEG) && ({1'b0, hc_nxt} < HS_END));
      vs_raw      <= !(({1'b0, vc_nxt} >= VS_BEG) && ({1'b0, vc_nxt} < VS_END));
    end
  end

  assign DrawX = hc;
  assign DrawY = vc;

  // Sync delay line; reset fills every stage with the inactive level so pulses in flight are squashed.
  generate
    if (PIPE_DELAY == 0) begin : g_no_dly
      assign hs = hs_raw;
      assign vs = vs_raw;
    end else if (PIPE_DELAY == 1) begin : g_dly1
      logic hs_q, vs_q;
      always_ff @(posedge vga_clk) begin
        if (reset) begin
          hs_q <= 1'b1;
          vs_q <= 1'b1;
        end else begin
          hs_q <= hs_raw;
          vs_q <= vs_raw;
        end
      end
      assign hs = hs_q;
      assign vs = vs_q;
    end else begin : g_dlyn
      logic [PIPE_DELAY-1:0] hs_sr, vs_sr;
      always_ff @(posedge vga_clk) begin
        if (reset) begin
          hs_sr <= '1;
          vs_sr <= '1;
        end else begin
          hs_sr <= {hs_sr[PIPE_DELAY-2:0], hs_raw};
          vs_sr <= {vs_sr[PIPE_DELAY-2:0], vs_raw};
        end
      end
      assign hs = hs_sr[PIPE_DELAY-1];
      assign vs = vs_sr[PIPE_DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks three builds of the timing generator against an arithmetic model.
// u0: default 640x480 timing, PIPE_DELAY=1. u1: shrunken 16x11 timing, PIPE_DELAY=2 (multi-frame and mid-frame reset).
// u2: default timing, PIPE_DELAY=0.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
  } obs_t;

  typedef struct {
    int ha, hfp, hsy, hbp;
    int va, vfp, vsy, vbp;
    int d;
  } cfg_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;

  logic [9:0] x0, y0, x1, y1, x2, y2;
  logic b0, hs0, vs0, ls0, fs0;
  logic b1, hs1, vs1, ls1, fs1;
  logic b2, hs2, vs2, ls2, fs2;

  int checks = 0;
  int errors = 0;

  vga_timing_gen #(.PIPE_DELAY(1)) u0 (
    .vga_clk(clk), .reset(rst0), .DrawX(x0), .DrawY(y0), .blank(b0),
    .hs(hs0), .vs(vs0), .line_start(ls0), .frame_start(fs0));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                   .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
                   .PIPE_DELAY(2)) u1 (
    .vga_clk(clk), .reset(rst1), .DrawX(x1), .DrawY(y1), .blank(b1),
    .hs(hs1), .vs(vs1), .line_start(ls1), .frame_start(fs1));

  vga_timing_gen #(.PIPE_DELAY(0)) u2 (
    .vga_clk(clk), .reset(rst2), .DrawX(x2), .DrawY(y2), .blank(b2),
    .hs(hs2), .vs(vs2), .line_start(ls2), .frame_start(fs2));

  localparam cfg_t C0 = '{640, 16, 96, 48, 480, 10, 2, 33, 1};
  localparam cfg_t C1 = '{8, 2, 3, 3, 6, 1, 2, 2, 2};
  localparam cfg_t C2 = '{640, 16, 96, 48, 480, 10, 2, 33, 0};

  // n = number of edges since reset release (0 on the first one), -1 while in reset.
  function automatic obs_t model(cfg_t c, int n);
    obs_t o;
    int ht, vt, x, y, m, xm, ym;
    ht = c.ha + c.hfp + c.hsy + c.hbp;
    vt = c.va + c.vfp + c.vsy + c.vbp;
    if (n < 0) begin
      o = '{x: 10'(ht - 1), y: 10'(vt - 1), blank: 1'b0, hs: 1'b1, vs: 1'b1, ls: 1'b0, fs: 1'b0};
      return o;
    end
    x = n % ht;
    y = (n / ht) % vt;
    o.x     = 10'(x);
    o.y     = 10'(y);
    o.blank = (x < c.ha) && (y < c.va);
    o.ls    = (x == 0);
    o.fs    = (x == 0) && (y == 0);
    m = n - c.d;
    if (m < 0) begin
      o.hs = 1'b1;
      o.vs = 1'b1;
    end else begin
      xm = m % ht;
      ym = (m / ht) % vt;
      o.hs = !((xm >= c.ha + c.hfp) && (xm < c.ha + c.hfp + c.hsy));
      o.vs = !((ym >= c.va + c.vfp) && (ym < c.va + c.vfp + c.vsy));
    end
    return o;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model state per instance, advanced on the same edge the DUT samples.
  int  n0 = -1, n1 = -1, n2 = -1;
  bit  v0 = 0, v1 = 0, v2 = 0;
  always @(posedge clk) begin
    n0 <= rst0 ? -1 : n0 + 1;
    n1 <= rst1 ? -1 : n1 + 1;
    n2 <= rst2 ? -1 : n2 + 1;
    v0 <= 1; v1 <= 1; v2 <= 1;
  end

  always @(negedge clk) begin
    obs_t e, a;
    if (v0) begin
      e = model(C0, n0);
      a = '{x0, y0, b0, hs0, vs0, ls0, fs0};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL model_u0 n=%0d: got x=%0d y=%0d b=%b hs=%b vs=%b ls=%b fs=%b, expected x=%0d y=%0d b=%b hs=%b vs=%b ls=%b fs=%b",
                 n0, a.x, a.y, a.blank, a.hs, a.vs, a.ls, a.fs, e.x, e.y, e.blank, e.hs, e.vs, e.ls, e.fs);
      end
    end
    if (v1) begin
      e = model(C1, n1);
      a = '{x1, y1, b1, hs1, vs1, ls1, fs1};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL model_u1 n=%0d: got x=%0d y=%0d b=%b hs=%b vs=%b ls=%b fs=%b, expected x=%0d y=%0d b=%b hs=%b vs=%b ls=%b fs=%b",
                 n1, a.x, a.y, a.blank, a.hs, a.vs, a.ls, a.fs, e.x, e.y, e.blank, e.hs, e.vs, e.ls, e.fs);
      end
    end
    if (v2) begin
      e = model(C2, n2);
      a = '{x2, y2, b2, hs2, vs2, ls2, fs2};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL model_u2 n=%0d: got x=%0d y=%0d b=%b hs=%b vs=%b ls=%b fs=%b, expected x=%0d y=%0d b=%b hs=%b vs=%b ls=%b fs=%b",
                 n2, a.x, a.y, a.blank, a.hs, a.vs, a.ls, a.fs, e.x, e.y, e.blank, e.hs, e.vs, e.ls, e.fs);
      end
    end
  end

  bit done0 = 0, done1 = 0, done2 = 0;

  // u0: reset values, frame wrap out of reset, one full line sweep, line wrap.
  initial begin
    int nblank, nls, nhs, fall_i, rise_i;
    int gap;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("u0_rst_x", x0, 799);
    chk("u0_rst_y", y0, 524);
    chk("u0_rst_blank", b0, 0);
    chk("u0_rst_hs", hs0, 1);
    chk("u0_rst_vs", vs0, 1);
    // Random extra reset cycles before release (model tracks them).
    gap = $urandom_range(0, 3);
    repeat (gap) @(negedge clk);
    rst0 = 1'b0;
    @(negedge clk);
    chk("u0_first_x", x0, 0);
    chk("u0_first_y", y0, 0);
    chk("u0_first_blank", b0, 1);
    chk("u0_first_fs", fs0, 1);
    nblank = 0; nls = 0; nhs = 0; fall_i = -1; rise_i = -1;
    for (int i = 0; i < 800; i++) begin
      if (b0) nblank++;
      if (ls0) nls++;
      if (!hs0) begin
        nhs++;
        if (fall_i < 0) fall_i = i;
      end else if (fall_i >= 0 && rise_i < 0) begin
        rise_i = i;
      end
      @(negedge clk);
    end
    chk("u0_line_blank_cycles", nblank, 640);
    chk("u0_line_start_count", nls, 1);
    chk("u0_hs_low_cycles", nhs, 96);
    chk("u0_hs_fall_index", fall_i, 657);
    chk("u0_hs_rise_index", rise_i, 753);
    chk("u0_wrap_x", x0, 0);
    chk("u0_wrap_y", y0, 1);
    // A few more random-length lines for the per-cycle model.
    repeat ($urandom_range(100, 900)) @(negedge clk);
    done0 = 1;
  end

  // u1: two frames of vsync, then a mid-frame reset inside both sync pulses.
  initial begin
    int nfs, nvs_first, fall0, fall1, rise0, k;
    bit prev;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst1 = 1'b0;
    @(negedge clk);
    nfs = 0; fall0 = -1; fall1 = -1; rise0 = -1; nvs_first = 0;
    prev = vs1;
    for (int i = 0; i < 352; i++) begin
      if (fs1) nfs++;
      if (prev && !vs1) begin
        if (fall0 < 0) fall0 = i; else if (fall1 < 0) fall1 = i;
      end
      if (!prev && vs1 && rise0 < 0) rise0 = i;
      if (!vs1 && i < 176) nvs_first++;
      prev = vs1;
      @(negedge clk);
    end
    chk("u1_frame_start_count", nfs, 2);
    chk("u1_vs_low_cycles_frame", nvs_first, 32);
    chk("u1_vs_first_fall", fall0, 114);
    chk("u1_vs_pulse_width", rise0 - fall0, 32);
    chk("u1_vs_fall_spacing", fall1 - fall0, 176);
    k = 0;
    while (!(x1 == 10'd13 && y1 == 10'd7) && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("u1_reach_target_in_budget", int'(k < 400), 1);
    chk("u1_pre_rst_hs", hs1, 0);
    chk("u1_pre_rst_vs", vs1, 0);
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    chk("u1_rst_hs", hs1, 1);
    chk("u1_rst_vs", vs1, 1);
    chk("u1_rst_x", x1, 15);
    chk("u1_rst_y", y1, 10);
    @(negedge clk);
    chk("u1_restart_x", x1, 0);
    chk("u1_restart_y", y1, 0);
    chk("u1_restart_fs", fs1, 1);
    repeat (200) @(negedge clk);
    done1 = 1;
  end

  // u2: zero-delay sync aligned with DrawX 656..751.
  initial begin
    int k;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst2 = 1'b0;
    k = 0;
    while (x2 != 10'd655 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("u2_reach_655_in_budget", int'(k < 1000), 1);
    chk("u2_hs_at_655", hs2, 1);
    @(negedge clk);
    chk("u2_hs_at_656", hs2, 0);
    repeat (95) @(negedge clk);
    chk("u2_x_at_751", x2, 751);
    chk("u2_hs_at_751", hs2, 0);
    @(negedge clk);
    chk("u2_hs_at_752", hs2, 1);
    done2 = 1;
  end

  initial begin
    fork
      wait (done0 && done1 && done2);
      #200000;
    join_any
    if (!(done0 && done1 && done2)) begin
      checks++;
      errors++;
      $display("FAIL timeout: done=%b%b%b, expected 111", done0, done1, done2);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
